// File: rtl/issue_queue_pkg.sv
// Shared types and sizing for the issue queue: renamed-op and redirect
// bundles, the queue entry, and the oldest-first k-select helper.
package issue_queue_pkg;

  localparam int RWD   = 2;
  localparam int IWD   = 2;
  localparam int WWD   = 2;
  localparam int IQSZ  = 16;
  localparam int PRNUM = 64;
  localparam int PW    = $clog2(PRNUM);

  typedef struct packed {
    logic [15:0]         opid;
    logic [1:0][PW-1:0]  prsa;
    logic [1:0][PW-1:0]  prda;
  } ren_bundle_t;

  typedef struct packed {
    logic [15:0] opid;
    logic        rollback;
  } red_bundle_t;

  typedef struct packed {
    ren_bundle_t op;
    logic [1:0]  rdy;
  } iq_entry_t;

  // Row k is one-hot on the k-th lowest set bit of req (all zero if none).
  function automatic logic [IWD-1:0][IQSZ-1:0] firstk(input logic [IQSZ-1:0] req);
    logic [IQSZ-1:0] rem;
    logic [IQSZ-1:0] one;
    rem    = req;
    one    = {{(IQSZ-1){1'b0}}, 1'b1};
    firstk = '0;
    for (int k = 0; k < IWD; k++) begin
      firstk[k] = rem & (~rem + one);
      rem       = rem & ~firstk[k];
    end
  endfunction

endpackage

// File: rtl/issue_queue_busy_table.sv
// Physical-register busy bits: set by dispatch, cleared by writeback, with
// writeback forwarded into the dispatch-time readiness lookups.
module busy_table
  import issue_queue_pkg::*;
#(
  parameter int prnum = 64,
  parameter int rwd   = 2,
  parameter int wwd   = 2,
  localparam int pw   = $clog2(prnum)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [rwd-1:0]            set_valid,
  input  logic [rwd-1:0][pw-1:0]    set_preg,
  input  logic [wwd-1:0]            clr_valid,
  input  logic [wwd-1:0][pw-1:0]    clr_preg,
  input  logic [2*rwd-1:0][pw-1:0]  rd_preg,
  output logic [2*rwd-1:0]          rd_ready
);

  logic [prnum-1:0] busy;
  logic [prnum-1:0] busy_next;

  // Clears first so a same-cycle set on the same register wins.
  always_comb begin
    busy_next = busy;
    for (int w = 0; w < wwd; w++)
      if (clr_valid[w]) busy_next[clr_preg[w]] = 1'b0;
    for (int i = 0; i < rwd; i++)
      if (set_valid[i]) busy_next[set_preg[i]] = 1'b1;
    busy_next[0] = 1'b0;
    if (flush) busy_next = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_next;
  end

  always_comb begin
    for (int r = 0; r < 2*rwd; r++) begin
      rd_ready[r] = (rd_preg[r] == '0) || !busy[rd_preg[r]];
      for (int w = 0; w < wwd; w++)
        if (clr_valid[w] && (clr_preg[w] == rd_preg[r])) rd_ready[r] = 1'b1;
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Unified age-ordered issue queue: dispatch from rename, wakeup from
// writeback, oldest-first select of up to iwd ready ops per cycle.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int rwd   = RWD,
  parameter int iwd   = IWD,
  parameter int wwd   = WWD,
  parameter int iqsz  = IQSZ,
  parameter int prnum = PRNUM,
  localparam int pw   = $clog2(prnum),
  localparam int nw   = $clog2(iqsz+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  red_bundle_t               red_bundle,
  input  ren_bundle_t [rwd-1:0]     ren_bundle,
  output logic [rwd-1:0]            rename,
  input  logic [wwd-1:0]            wb_valid,
  input  logic [wwd-1:0][pw-1:0]    wb_preg,
  output ren_bundle_t [iwd-1:0]     iss_bundle,
  input  logic [iwd-1:0]            iss_ready
);

  iq_entry_t                q      [iqsz];
  iq_entry_t                q_next [iqsz];
  logic [nw-1:0]            iq_num;
  logic [nw-1:0]            num_next;
  logic [nw-1:0]            free;
  logic [iqsz-1:0]          valid, elig, issued;
  logic [iwd-1:0][iqsz-1:0] sel;
  logic [1:0]               wake [iqsz];
  logic [rwd-1:0][1:0]      lane_rdy;
  logic [rwd-1:0]           set_valid;
  logic [rwd-1:0][pw-1:0]   set_preg;
  logic [2*rwd-1:0][pw-1:0] rd_preg;
  logic [2*rwd-1:0]         rd_ready;
  logic                     unused_red;

  assign unused_red = ^red_bundle.opid[14:0];
  assign free       = nw'(iqsz) - iq_num;

  always_comb begin
    for (int i = 0; i < iqsz; i++) begin
      valid[i] = nw'(i) < iq_num;
      elig[i]  = valid[i] && (&q[i].rdy);
    end
    sel = firstk(elig);
  end

  always_comb begin
    issued = '0;
    for (int k = 0; k < iwd; k++) begin
      iss_bundle[k] = '0;
      for (int i = 0; i < iqsz; i++)
        if (sel[k][i]) begin
          iss_bundle[k] = q[i].op;
          issued[i]     = iss_ready[k];
        end
    end
    if (!rst) iss_bundle = '0;
  end

  // Accept is a prefix of valid lanes that fits the space held before this edge.
  always_comb begin
    logic ok;
    ok = rst && !red_bundle.opid[15] && !red_bundle.rollback;
    for (int i = 0; i < rwd; i++) begin
      ok        = ok && ren_bundle[i].opid[15] && (nw'(i) < free);
      rename[i] = ok;
    end
  end

  always_comb begin
    logic dep;
    for (int i = 0; i < rwd; i++)
      for (int s = 0; s < 2; s++) begin
        dep = 1'b0;
        for (int j = 0; j < i; j++)
          if (rename[j] && (ren_bundle[j].prda[1] == ren_bundle[i].prsa[s]) &&
              (ren_bundle[i].prsa[s] != '0))
            dep = 1'b1;
        lane_rdy[i][s] = rd_ready[2*i+s] && !dep;
      end
  end

  for (genvar gi = 0; gi < rwd; gi++) begin : g_lane
    assign set_valid[gi]   = rename[gi] && (ren_bundle[gi].prda[1] != '0);
    assign set_preg[gi]    = ren_bundle[gi].prda[1];
    assign rd_preg[2*gi]   = ren_bundle[gi].prsa[0];
    assign rd_preg[2*gi+1] = ren_bundle[gi].prsa[1];
  end

  for (genvar gi = 0; gi < iqsz; gi++) begin : g_wake
    logic [1:0][wwd-1:0] hit;
    for (genvar gw = 0; gw < wwd; gw++) begin : g_w
      assign hit[0][gw] = wb_valid[gw] && (wb_preg[gw] == q[gi].op.prsa[0]);
      assign hit[1][gw] = wb_valid[gw] && (wb_preg[gw] == q[gi].op.prsa[1]);
    end
    assign wake[gi] = {|hit[1], |hit[0]};
  end

  busy_table #(.prnum(prnum), .rwd(rwd), .wwd(wwd)) u_busy (
    .clk       (clk),
    .rst       (rst),
    .flush     (red_bundle.opid[15]),
    .set_valid (set_valid),
    .set_preg  (set_preg),
    .clr_valid (wb_valid),
    .clr_preg  (wb_preg),
    .rd_preg   (rd_preg),
    .rd_ready  (rd_ready)
  );

  // Drop issued entries, slide survivors down in age order, append accepts.
  always_comb begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < iqsz; i++) q_next[i] = q[i];
    for (int i = 0; i < iqsz; i++)
      if (valid[i] && !issued[i]) begin
        q_next[cnt]     = q[i];
        q_next[cnt].rdy = q[i].rdy | wake[i];
        cnt++;
      end
    for (int l = 0; l < rwd; l++)
      if (rename[l]) begin
        if (cnt < iqsz) begin
          q_next[cnt].op  = ren_bundle[l];
          q_next[cnt].rdy = lane_rdy[l];
        end
        cnt++;
      end
    num_next = nw'(cnt);
    if (red_bundle.opid[15]) num_next = '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < iqsz; i++) q[i] <= q_next[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) iq_num <= '0;
    else      iq_num <= num_next;
  end

endmodule

// File: tb/tb_issue_queue.sv
// Scenario bench for issue_queue: expected issue order is queued as ops are
// driven and popped when the DUT offers them on an issue lane.
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  red_bundle_t           red_bundle;
  ren_bundle_t [1:0]     ren_bundle;
  logic [1:0]            rename;
  logic [1:0]            wb_valid;
  logic [1:0][PW-1:0]    wb_preg;
  ren_bundle_t [1:0]     iss_bundle;
  logic [1:0]            iss_ready;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q [$];
  logic [15:0] exp;

  always #5 clk = ~clk;

  issue_queue dut (
    .clk        (clk),
    .rst        (rst),
    .red_bundle (red_bundle),
    .ren_bundle (ren_bundle),
    .rename     (rename),
    .wb_valid   (wb_valid),
    .wb_preg    (wb_preg),
    .iss_bundle (iss_bundle),
    .iss_ready  (iss_ready)
  );

  function automatic ren_bundle_t mk(input int id, input int s0, input int s1, input int d);
    ren_bundle_t r;
    r.opid    = 16'h8000 | 16'(id);
    r.prsa[0] = PW'(s0);
    r.prsa[1] = PW'(s1);
    r.prda[0] = '0;
    r.prda[1] = PW'(d);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    ren_bundle = '0;
    red_bundle = '0;
    wb_valid   = '0;
    wb_preg    = '0;
    iss_ready  = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    ren_bundle[0] = mk(1, 0, 0, 1);
    #2;
    n_checks++; if (rename !== 2'b00) begin n_fail++; $display("FAIL reset_rename: got %b want 00", rename); end
    n_checks++; if (iss_bundle[0].opid !== 16'h0) begin n_fail++; $display("FAIL reset_iss0: got %h want 0000", iss_bundle[0].opid); end
    n_checks++; if (iss_bundle[1].opid !== 16'h0) begin n_fail++; $display("FAIL reset_iss1: got %h want 0000", iss_bundle[1].opid); end
    #5;
    rst = 1'b1;
    idle();
    tick();
    n_checks++; if (iss_bundle[0].opid !== 16'h0) begin n_fail++; $display("FAIL reset_empty: got %h want 0000", iss_bundle[0].opid); end
  endtask

  task automatic test_independent;
    ren_bundle[0] = mk(1, 0, 0, 5);
    ren_bundle[1] = mk(2, 0, 0, 6);
    iss_ready = 2'b11;
    #1;
    n_checks++; if (rename !== 2'b11) begin n_fail++; $display("FAIL indep_rename: got %b want 11", rename); end
    n_checks++; if (iss_bundle[0].opid !== 16'h0) begin n_fail++; $display("FAIL indep_same_cycle: got %h want 0000", iss_bundle[0].opid); end
    exp_q.push_back(16'h8001);
    exp_q.push_back(16'h8002);
    tick();
    ren_bundle[0] = mk(3, 5, 0, 0);
    ren_bundle[1] = mk(4, 0, 6, 0);
    #1;
    exp = exp_q.pop_front(); $display("txn issue lane0 expect %h", exp);
    n_checks++; if (iss_bundle[0].opid !== exp) begin n_fail++; $display("FAIL indep_iss0: got %h want %h", iss_bundle[0].opid, exp); end
    exp = exp_q.pop_front(); $display("txn issue lane1 expect %h", exp);
    n_checks++; if (iss_bundle[1].opid !== exp) begin n_fail++; $display("FAIL indep_iss1: got %h want %h", iss_bundle[1].opid, exp); end
    tick();
    ren_bundle = '0;
    wb_valid   = 2'b11;
    wb_preg[0] = PW'(5);
    wb_preg[1] = PW'(6);
    #1;
    n_checks++; if (iss_bundle[0].opid !== 16'h0) begin n_fail++; $display("FAIL busy56_blocks: got %h want 0000", iss_bundle[0].opid); end
    exp_q.push_back(16'h8003);
    exp_q.push_back(16'h8004);
    tick();
    wb_valid = '0;
    #1;
    exp = exp_q.pop_front(); $display("txn issue lane0 expect %h", exp);
    n_checks++; if (iss_bundle[0].opid !== exp) begin n_fail++; $display("FAIL wake_iss0: got %h want %h", iss_bundle[0].opid, exp); end
    exp = exp_q.pop_front(); $display("txn issue lane1 expect %h", exp);
    n_checks++; if (iss_bundle[1].opid !== exp) begin n_fail++; $display("FAIL wake_iss1: got %h want %h", iss_bundle[1].opid, exp); end
    tick();
    idle();
  endtask

  task automatic test_dependency;
    ren_bundle[0] = mk(10, 0, 0, 5);
    ren_bundle[1] = mk(11, 5, 0, 9);
    iss_ready = 2'b11;
    #1;
    n_checks++; if (rename !== 2'b11) begin n_fail++; $display("FAIL dep_rename: got %b want 11", rename); end
    exp_q.push_back(16'h800a);
    tick();
    ren_bundle = '0;
    #1;
    exp = exp_q.pop_front(); $display("txn issue lane0 expect %h", exp);
    n_checks++; if (iss_bundle[0].opid !== exp) begin n_fail++; $display("FAIL dep_producer: got %h want %h", iss_bundle[0].opid, exp); end
    n_checks++; if (iss_bundle[1].opid !== 16'h0) begin n_fail++; $display("FAIL dep_held: got %h want 0000", iss_bundle[1].opid); end
    tick();
    n_checks++; if (iss_bundle[0].opid !== 16'h0) begin n_fail++; $display("FAIL dep_still_held: got %h want 0000", iss_bundle[0].opid); end
    tick();
    wb_valid   = 2'b01;
    wb_preg[0] = PW'(5);
    #1;
    n_checks++; if (iss_bundle[0].opid !== 16'h0) begin n_fail++; $display("FAIL dep_no_bypass: got %h want 0000", iss_bundle[0].opid); end
    exp_q.push_back(16'h800b);
    tick();
    wb_valid = '0;
    #1;
    exp = exp_q.pop_front(); $display("txn issue lane0 expect %h", exp);
    n_checks++; if (iss_bundle[0].opid !== exp) begin n_fail++; $display("FAIL dep_woken: got %h want %h", iss_bundle[0].opid, exp); end
    tick();
    ren_bundle[0] = mk(12, 0, 0, 7);
    exp_q.push_back(16'h800c);
    tick();
    ren_bundle[0] = mk(13, 7, 7, 0);
    wb_valid   = 2'b01;
    wb_preg[0] = PW'(7);
    #1;
    exp = exp_q.pop_front(); $display("txn issue lane0 expect %h", exp);
    n_checks++; if (iss_bundle[0].opid !== exp) begin n_fail++; $display("FAIL fwd_producer: got %h want %h", iss_bundle[0].opid, exp); end
    exp_q.push_back(16'h800d);
    tick();
    ren_bundle = '0;
    wb_valid   = '0;
    #1;
    exp = exp_q.pop_front(); $display("txn issue lane0 expect %h", exp);
    n_checks++; if (iss_bundle[0].opid !== exp) begin n_fail++; $display("FAIL fwd_ready_at_dispatch: got %h want %h", iss_bundle[0].opid, exp); end
    n_checks++; if (iss_bundle[1].opid !== 16'h0) begin n_fail++; $display("FAIL fwd_lane1: got %h want 0000", iss_bundle[1].opid); end
    tick();
    idle();
  endtask

  task automatic test_full;
    ren_bundle[0] = mk(20, 0, 0, 20);
    ren_bundle[1] = mk(21, 20, 0, 0);
    iss_ready = 2'b00;
    #1;
    n_checks++; if (rename !== 2'b11) begin n_fail++; $display("FAIL full_fill0: got %b want 11", rename); end
    tick();
    for (int c = 0; c < 7; c++) begin
      ren_bundle[0] = mk(22 + 2*c, 20, 0, 0);
      ren_bundle[1] = mk(23 + 2*c, 20, 0, 0);
      #1;
      n_checks++; if (rename !== 2'b11) begin n_fail++; $display("FAIL full_fill%0d: got %b want 11", c+1, rename); end
      tick();
    end
    ren_bundle[0] = mk(40, 20, 0, 0);
    ren_bundle[1] = mk(41, 20, 0, 0);
    #1;
    n_checks++; if (rename !== 2'b00) begin n_fail++; $display("FAIL full_rename: got %b want 00", rename); end
    n_checks++; if (iss_bundle[0].opid !== 16'h8014) begin n_fail++; $display("FAIL full_offer0: got %h want 8014", iss_bundle[0].opid); end
    n_checks++; if (iss_bundle[1].opid !== 16'h0) begin n_fail++; $display("FAIL full_offer1: got %h want 0000", iss_bundle[1].opid); end
    tick();
    iss_ready = 2'b01;
    #1;
    n_checks++; if (rename !== 2'b00) begin n_fail++; $display("FAIL full_issue_no_free: got %b want 00", rename); end
    exp_q.push_back(16'h8014);
    exp = exp_q.pop_front(); $display("txn issue lane0 expect %h", exp);
    n_checks++; if (iss_bundle[0].opid !== exp) begin n_fail++; $display("FAIL full_issue: got %h want %h", iss_bundle[0].opid, exp); end
    tick();
    iss_ready = 2'b00;
    #1;
    n_checks++; if (rename !== 2'b01) begin n_fail++; $display("FAIL full_one_free: got %b want 01", rename); end
    n_checks++; if (iss_bundle[0].opid !== 16'h0) begin n_fail++; $display("FAIL full_after_issue: got %h want 0000", iss_bundle[0].opid); end
    tick();
    ren_bundle = '0;
    red_bundle.opid = 16'h8000;
    tick();
    idle();
  endtask

  task automatic test_order;
    ren_bundle[0] = mk(50, 0, 0, 0);
    ren_bundle[1] = mk(51, 0, 0, 0);
    iss_ready = 2'b00;
    tick();
    ren_bundle[0] = mk(52, 0, 0, 0);
    ren_bundle[1] = '0;
    tick();
    ren_bundle = '0;
    iss_ready  = 2'b01;
    #1;
    exp_q.push_back(16'h8032);
    exp = exp_q.pop_front(); $display("txn issue lane0 expect %h", exp);
    n_checks++; if (iss_bundle[0].opid !== exp) begin n_fail++; $display("FAIL order_a: got %h want %h", iss_bundle[0].opid, exp); end
    n_checks++; if (iss_bundle[1].opid !== 16'h8033) begin n_fail++; $display("FAIL order_b_offer: got %h want 8033", iss_bundle[1].opid); end
    tick();
    iss_ready = 2'b11;
    #1;
    exp_q.push_back(16'h8033);
    exp_q.push_back(16'h8034);
    exp = exp_q.pop_front(); $display("txn issue lane0 expect %h", exp);
    n_checks++; if (iss_bundle[0].opid !== exp) begin n_fail++; $display("FAIL order_b: got %h want %h", iss_bundle[0].opid, exp); end
    exp = exp_q.pop_front(); $display("txn issue lane1 expect %h", exp);
    n_checks++; if (iss_bundle[1].opid !== exp) begin n_fail++; $display("FAIL order_c: got %h want %h", iss_bundle[1].opid, exp); end
    tick();
    iss_ready = 2'b00;
    #1;
    n_checks++; if (iss_bundle[0].opid !== 16'h0) begin n_fail++; $display("FAIL order_empty: got %h want 0000", iss_bundle[0].opid); end
    idle();
  endtask

  task automatic test_redirect;
    iss_ready = 2'b00;
    ren_bundle[0] = mk(60, 0, 0, 50);
    ren_bundle[1] = mk(61, 50, 0, 0);
    tick();
    for (int c = 0; c < 2; c++) begin
      ren_bundle[0] = mk(62 + 2*c, 50, 0, 0);
      ren_bundle[1] = mk(63 + 2*c, 50, 0, 0);
      tick();
    end
    ren_bundle[0]   = mk(66, 0, 0, 0);
    ren_bundle[1]   = mk(67, 0, 0, 0);
    red_bundle.opid = 16'h8001;
    iss_ready       = 2'b11;
    #1;
    n_checks++; if (rename !== 2'b00) begin n_fail++; $display("FAIL redir_rename: got %b want 00", rename); end
    tick();
    red_bundle    = '0;
    ren_bundle[0] = mk(70, 50, 0, 0);
    ren_bundle[1] = mk(71, 0, 0, 0);
    #1;
    n_checks++; if (iss_bundle[0].opid !== 16'h0) begin n_fail++; $display("FAIL redir_no_issue0: got %h want 0000", iss_bundle[0].opid); end
    n_checks++; if (iss_bundle[1].opid !== 16'h0) begin n_fail++; $display("FAIL redir_no_issue1: got %h want 0000", iss_bundle[1].opid); end
    n_checks++; if (rename !== 2'b11) begin n_fail++; $display("FAIL redir_accept: got %b want 11", rename); end
    exp_q.push_back(16'h8046);
    exp_q.push_back(16'h8047);
    tick();
    ren_bundle = '0;
    #1;
    exp = exp_q.pop_front(); $display("txn issue lane0 expect %h", exp);
    n_checks++; if (iss_bundle[0].opid !== exp) begin n_fail++; $display("FAIL redir_busy_clear: got %h want %h", iss_bundle[0].opid, exp); end
    exp = exp_q.pop_front(); $display("txn issue lane1 expect %h", exp);
    n_checks++; if (iss_bundle[1].opid !== exp) begin n_fail++; $display("FAIL redir_lane1: got %h want %h", iss_bundle[1].opid, exp); end
    tick();
    iss_ready     = 2'b00;
    ren_bundle[0] = mk(72, 0, 0, 0);
    tick();
    ren_bundle[0]       = mk(73, 0, 0, 0);
    red_bundle.rollback = 1'b1;
    iss_ready           = 2'b01;
    #1;
    n_checks++; if (rename !== 2'b00) begin n_fail++; $display("FAIL rollback_rename: got %b want 00", rename); end
    exp_q.push_back(16'h8048);
    exp = exp_q.pop_front(); $display("txn issue lane0 expect %h", exp);
    n_checks++; if (iss_bundle[0].opid !== exp) begin n_fail++; $display("FAIL rollback_issue: got %h want %h", iss_bundle[0].opid, exp); end
    tick();
    red_bundle = '0;
    ren_bundle = '0;
    #1;
    n_checks++; if (iss_bundle[0].opid !== 16'h0) begin n_fail++; $display("FAIL rollback_drained: got %h want 0000", iss_bundle[0].opid); end
    tick();
    idle();
  endtask

  task automatic test_async_reset;
    ren_bundle[0] = mk(80, 0, 0, 0);
    iss_ready     = 2'b00;
    tick();
    ren_bundle = '0;
    #1;
    n_checks++; if (iss_bundle[0].opid !== 16'h8050) begin n_fail++; $display("FAIL arst_resident: got %h want 8050", iss_bundle[0].opid); end
    #2;
    rst = 1'b0;
    ren_bundle[0] = mk(81, 0, 0, 0);
    #1;
    n_checks++; if (iss_bundle[0].opid !== 16'h0) begin n_fail++; $display("FAIL arst_iss: got %h want 0000", iss_bundle[0].opid); end
    n_checks++; if (rename !== 2'b00) begin n_fail++; $display("FAIL arst_rename: got %b want 00", rename); end
    #1;
    rst = 1'b1;
    ren_bundle = '0;
    tick();
    n_checks++; if (iss_bundle[0].opid !== 16'h0) begin n_fail++; $display("FAIL arst_empty0: got %h want 0000", iss_bundle[0].opid); end
    n_checks++; if (iss_bundle[1].opid !== 16'h0) begin n_fail++; $display("FAIL arst_empty1: got %h want 0000", iss_bundle[1].opid); end
  endtask

  initial begin
    idle();
    test_reset();
    test_independent();
    test_dependency();
    test_full();
    test_order();
    test_redirect();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_queue.md
# issue_queue

Unified out-of-order issue queue directly downstream of the rename stage. It accepts up to `rwd` renamed ops per cycle from the rename queue, tracks operand readiness through an internal physical-register busy table updated by writeback wakeups, and issues up to `iwd` ready ops per cycle in oldest-first order to the execution units. Redirects squash the whole queue, because redirects are raised at commit.

## Interface
- `rwd`, 2: rename/dispatch width; must match rename stage.
- `iwd`, 2: issue width (number of issue ports).
- `wwd`, 2: writeback/wakeup width.
- `iqsz`, 16: queue entries; must satisfy `iqsz >= rwd + iwd`.
- `prnum`, 64: physical registers; `pw = $clog2(prnum)`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; `rst==0` clears all state immediately.
- `red_bundle`  in  `red_bundle_t`  redirect; `opid[15]` marks a redirect, and `rollback` marks a rename rollback.
- `ren_bundle`  in  `ren_bundle_t [rwd-1:0]`  renamed ops; lane valid = `opid[15]`; valid lanes form a prefix.
- `rename`  out  `[rwd-1:0]`  per-lane accept back to the rename stage.
- `wb_valid`  in  `[wwd-1:0]`  wakeup valid.
- `wb_preg`  in  `[wwd-1:0][pw-1:0]`  physical destination being written back.
- `iss_bundle`  out  `ren_bundle_t [iwd-1:0]`  issued ops; valid = `opid[15]`.
- `iss_ready`  in  `[iwd-1:0]`  the execution port consumes `iss_bundle[k]` this cycle.

## Operation
- **Entry contents.** Each entry holds a `ren_bundle_t`, a valid bit, and `rdy[1:0]` for `prsa[0]` and `prsa[1]`. Entries are kept age-ordered: slot 0 is the oldest, and the valid entries occupy slots `0..iq_num-1`.
- **Busy table.** `prnum` bits. Bit 0 is always 0.
  - Set on the edge when an accepted op has `prda[1] != 0`.
  - Cleared on the edge of any matching `wb_valid`/`wb_preg`.
  - If a set and a clear hit the same register in one cycle, the set wins.
- **Accept.**
  - `rename[i] = 1` iff lane `i` is valid, `i < iqsz - iq_num`, and all lower lanes are accepted.
  - The free count uses the current `iq_num` only; same-cycle issues do not free space.
  - `rename` is all 0 when `red_bundle.opid[15]` or `red_bundle.rollback` is set.
- **Source readiness at dispatch.** `rdy[s] = 1` when any of these holds:
  - `prsa[s] == 0`;
  - the busy bit for `prsa[s]` is clear;
  - a same-cycle `wb_preg` matches `prsa[s]`.
  - Intra-bundle dependency overrides all of the above: if an older accepted lane `j < i` in the same bundle has `prda[1] == prsa[s] != 0`, then `rdy[s] = 0`.
- **Wakeup.** A resident entry whose source matches a valid `wb_preg` sets that `rdy` bit on the edge.
- **Select.**
  - An entry is eligible when `&rdy` holds.
  - `iss_bundle[k]` is the k-th oldest eligible entry, found by `firstk` over the eligibility vector.
  - Lanes with no eligible entry have `opid = 0`.
  - Selection is combinational from registered state.
- **Issue.** An entry leaves on the edge iff its lane has `iss_ready[k]`. Unconsumed selections stay in place and are re-selected next cycle.
- **Compaction.** Each edge applies, in order:
  1. remove issued entries;
  2. shift the survivors down, preserving order;
  3. append accepted lanes at the tail, in lane order.
  - `iq_num_next = iq_num - issued + accepted`.
- **Redirect** (`red_bundle.opid[15]`): on the edge, all entries are invalidated, the busy table is cleared, `iq_num = 0`, and same-cycle accepts and issues are discarded.
- **Rollback.** While `red_bundle.rollback` is asserted, entries still issue normally.

## Timing
- **Reset values.** `rename = 0` and every `iss_bundle[k].opid = 0`; `iq_num = 0` and the busy table is all 0.
- **Dispatch to issue.**
  - An op accepted in cycle t with both sources ready appears on `iss_bundle` in cycle t+1 at the earliest.
  - If a source is woken in cycle t+n, the op is eligible in cycle t+n+1.
- **Wakeup to issue.** One cycle; there is no same-cycle wakeup-to-select bypass.
- **Full.** At `iq_num == iqsz`, `rename = 0` even if an issue fires that cycle; the freed slot is usable in the next cycle.
- **Empty.** All `iss_bundle` lanes are invalid.
- **Reset mid-operation.** When `rst` falls, outputs go to their reset values without waiting for a clock edge. The queue is empty once `rst` returns high.

## Structure
- `types` package:
  - reuse `ren_bundle_t` and `red_bundle_t`;
  - add `iq_entry_t` (`ren_bundle_t` op, `logic [1:0] rdy`).
- Reuse the existing `firstk` for the select logic.
- One new sub-module, `busy_table`, parameters `prnum`, `rwd`, `wwd`:
  - `rwd` set ports and `wwd` clear ports;
  - a flush input;
  - a combinational read port with wakeup forwarding, giving `2*rwd` lookups.

## Test plan
- **Independent ops.** Two valid lanes with `prsa = 0` and `prda[1] = 5, 6`, and `iss_ready = 2'b11`. Required: `rename = 2'b11`; both ops issue in cycle t+1, lane 0 first; busy bits 5 and 6 are set.
- **Dependency and same-cycle wakeup.** Lane 1 `prsa[0] = 5` depends on lane 0 `prda[1] = 5`, so lane 1 is held. Wakeup `wb_preg = 5` arrives in cycle t+3, and lane 1 issues in cycle t+4. A separate case dispatches an op with `prsa = 7` in the same cycle as `wb_preg = 7`; it is ready at dispatch and issues next cycle.
- **Full queue.** Fill to `iqsz = 16` with blocked ops. Required: `rename = 0`. Then issue one op; the next cycle `rename = 2'b01`.
- **Oldest-first order.** Entries A, B, C are all eligible with `iwd = 2`. Required: A and B are issued. With `iss_ready = 2'b01`, A leaves; the next cycle offers B and C.
- **Redirect.** Redirect with 6 entries resident and a dispatch pending. Required: next cycle `iq_num = 0`, the busy table is clear, and there is no issue. During `rollback`, `rename` stays 0.
- **Asynchronous reset.** Assert `rst = 0` between edges. Required: outputs are cleared immediately.
